mavg_channel_scheduler: RTL and testbench



---
 rtl/mavg_sched_if.sv | 43 ++++
 rtl/mavg_channel_scheduler.sv | 128 ++++++++++++
 tb/tb_mavg_channel_scheduler.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mavg_sched_if.sv
// Requester/filter bus for mavg_channel_scheduler: sources, grants, responses and filter push/result.
// The optional hi_pri vector exists only when MAVG_SCHED_PRIORITY_EN is defined.
interface mavg_sched_if #(
    parameter int NUM_REQ  = 4,
    parameter int SAMPLE_W = 6,
    parameter int ID_W     = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*SAMPLE_W-1:0] req_data;
    logic [NUM_REQ-1:0]          gnt;
    logic                        rsp_valid;
    logic [ID_W-1:0]             rsp_id;
    logic [SAMPLE_W-1:0]         rsp_data;
    logic                        flt_push;
    logic [ID_W-1:0]             flt_sel;
    logic [SAMPLE_W-1:0]         flt_data;
    logic                        flt_valid;
    logic [SAMPLE_W-1:0]         flt_result;
    logic                        busy;
    logic                        err_timeout;
`ifdef MAVG_SCHED_PRIORITY_EN
    logic [NUM_REQ-1:0]          hi_pri;
`endif

    // master: requesters plus the filter engine; slave: the scheduler
    modport master (
`ifdef MAVG_SCHED_PRIORITY_EN
        output hi_pri,
`endif
        output req, req_data, flt_valid, flt_result,
        input  gnt, rsp_valid, rsp_id, rsp_data, flt_push, flt_sel, flt_data,
               busy, err_timeout
    );

    modport slave (
`ifdef MAVG_SCHED_PRIORITY_EN
        input  hi_pri,
`endif
        input  req, req_data, flt_valid, flt_result,
        output gnt, rsp_valid, rsp_id, rsp_data, flt_push, flt_sel, flt_data,
               busy, err_timeout
    );
endinterface

// File: rtl/mavg_channel_scheduler.sv
// Round-robin arbiter sharing one moving-average filter among NUM_REQ sources, with WAIT timeout.
// Optional MAVG_SCHED_PRIORITY_EN restricts arbitration to high-priority requesters when any are pending.
module mavg_channel_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int SAMPLE_W = 6,
    parameter int TIMEOUT  = 15,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic         clk,
    input  logic         rst_n,   // active-high asynchronous reset
    mavg_sched_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e              state_q;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     win_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [SAMPLE_W-1:0] rsp_data_q;
    logic                flt_push_q;
    logic [ID_W-1:0]     flt_sel_q;
    logic [SAMPLE_W-1:0] flt_data_q;
    logic                busy_q;
    logic                err_q;

    logic [NUM_REQ-1:0]  cand;
    logic [ID_W-1:0]     win_d;
    logic [SAMPLE_W-1:0] win_data_d;
    logic                found;
    int                  arb_idx;

    always_comb begin
        cand = bus.req;
`ifdef MAVG_SCHED_PRIORITY_EN
        if (|(bus.req & bus.hi_pri)) cand = bus.req & bus.hi_pri;
`endif
        win_d   = '0;
        found   = 1'b0;
        arb_idx = 0;
        // first set candidate at or above rr_ptr, wrapping around
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_idx = int'(rr_ptr_q) + i;
            if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
            if (!found && cand[arb_idx]) begin
                found = 1'b1;
                win_d = ID_W'(arb_idx);
            end
        end
        win_data_d = bus.req_data[win_d*SAMPLE_W +: SAMPLE_W];
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            flt_push_q  <= 1'b0;
            flt_sel_q   <= '0;
            flt_data_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        state_q    <= S_ISSUE;
                        win_q      <= win_d;
                        flt_push_q <= 1'b1;
                        flt_sel_q  <= win_d;
                        flt_data_q <= win_data_d;
                        gnt_q      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_d;
                        busy_q     <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    flt_push_q <= 1'b0;
                    cnt_q      <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    // a result arriving on the timeout cycle still wins
                    if (bus.flt_valid) begin
                        rsp_data_q  <= bus.flt_result;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= win_q;
                        state_q     <= S_RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        rsp_data_q  <= '0;
                        err_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= win_q;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    rsp_valid_q <= 1'b0;
                    gnt_q       <= '0;
                    busy_q      <= 1'b0;
                    rr_ptr_q    <= (win_q == ID_W'(NUM_REQ-1)) ? '0 : win_q + 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.flt_push    = flt_push_q;
    assign bus.flt_sel     = flt_sel_q;
    assign bus.flt_data    = flt_data_q;
    assign bus.busy        = busy_q;
    assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_mavg_channel_scheduler.sv
// Directed bench for mavg_channel_scheduler: single request, fairness, timeout, race, reset, withdrawal.
module tb_mavg_channel_scheduler;
    localparam int T = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    mavg_sched_if #(.NUM_REQ(4), .SAMPLE_W(6)) bus_if ();

    mavg_channel_scheduler #(.NUM_REQ(4), .SAMPLE_W(6), .TIMEOUT(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus_if.req = '0; bus_if.req_data = '0;
        bus_if.flt_valid = 1'b0; bus_if.flt_result = '0;
`ifdef MAVG_SCHED_PRIORITY_EN
        bus_if.hi_pri = '0;
`endif
        tick(); tick();
        total++;
        if ({bus_if.gnt, bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_data, bus_if.flt_push,
             bus_if.flt_sel, bus_if.flt_data} !== 23'd0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", {bus_if.gnt, bus_if.rsp_valid,
                bus_if.rsp_id, bus_if.rsp_data, bus_if.flt_push, bus_if.flt_sel, bus_if.flt_data});
        end
        total++;
        if ({bus_if.busy, bus_if.err_timeout} !== 2'b00) begin
            bad++; $display("FAIL reset_flags got=%b exp=00", {bus_if.busy, bus_if.err_timeout});
        end
        rst_n = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bus_if.req_data = '0; bus_if.req_data[11:6] = 6'h2D; bus_if.req = 4'b0010;
        tick();
        bus_if.req_data = '1;
        total++;
        if ({bus_if.flt_push, bus_if.flt_sel, bus_if.flt_data, bus_if.gnt} !== {1'b1, 2'd1, 6'h2D, 4'b0010}) begin
            bad++; $display("FAIL single_issue got push=%b sel=%0d data=%h gnt=%b exp 1 1 2d 0010",
                bus_if.flt_push, bus_if.flt_sel, bus_if.flt_data, bus_if.gnt);
        end
        tick();
        total++;
        if ({bus_if.flt_push, bus_if.rsp_valid, bus_if.gnt} !== {2'b00, 4'b0010}) begin
            bad++; $display("FAIL single_wait got push=%b rv=%b gnt=%b exp 0 0 0010",
                bus_if.flt_push, bus_if.rsp_valid, bus_if.gnt);
        end
        bus_if.flt_valid = 1'b1; bus_if.flt_result = 6'h15; bus_if.req = '0;
        tick();
        bus_if.flt_valid = 1'b0;
        total++;
        if ({bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_data, bus_if.gnt} !== {1'b1, 2'd1, 6'h15, 4'b0010}) begin
            bad++; $display("FAIL single_resp got rv=%b id=%0d data=%h gnt=%b exp 1 1 15 0010",
                bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_data, bus_if.gnt);
        end
        tick();
        total++;
        if ({bus_if.rsp_valid, bus_if.gnt, bus_if.busy} !== 6'd0) begin
            bad++; $display("FAIL single_idle got rv=%b gnt=%b busy=%b exp 0",
                bus_if.rsp_valid, bus_if.gnt, bus_if.busy);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] e_id;
        logic [3:0] e_gnt;
        test_reset();
        bus_if.req_data = {6'h04, 6'h03, 6'h02, 6'h01};
        bus_if.req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            e_id = 2'(k % 4);
            e_gnt = 4'b0001 << e_id;
            total++;
            if ({bus_if.flt_push, bus_if.flt_sel, bus_if.gnt, bus_if.flt_data} !== {1'b1, e_id, e_gnt, 6'(k % 4 + 1)}) begin
                bad++; $display("FAIL rr_issue%0d got push=%b sel=%0d gnt=%b data=%h exp sel=%0d",
                    k, bus_if.flt_push, bus_if.flt_sel, bus_if.gnt, bus_if.flt_data, e_id);
            end
            tick();
            bus_if.flt_valid = 1'b1; bus_if.flt_result = 6'h10 + 6'(e_id);
            tick();
            bus_if.flt_valid = 1'b0;
            total++;
            if ({bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_data} !== {1'b1, e_id, 6'h10 + 6'(e_id)}) begin
                bad++; $display("FAIL rr_resp%0d got rv=%b id=%0d data=%h exp id=%0d",
                    k, bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_data, e_id);
            end
            tick();
            if (k == 4) bus_if.req = '0;
            tick();
        end
    endtask

    task automatic test_timeout();
        test_reset();
        bus_if.req_data = '0; bus_if.req_data[5:0] = 6'h03; bus_if.req = 4'b0001;
        tick();
        bus_if.req = '0;
        for (int k = 1; k <= T + 2; k++) begin
            tick();
            if (k < T + 2) begin
                total++;
                if (bus_if.rsp_valid !== 1'b0) begin
                    bad++; $display("FAIL timeout_early k=%0d got rv=%b exp 0", k, bus_if.rsp_valid);
                end
            end
            if (k == T + 1) begin
                total++;
                if (bus_if.err_timeout !== 1'b0) begin
                    bad++; $display("FAIL timeout_err_early got=%b exp 0", bus_if.err_timeout);
                end
            end
            if (k == T + 2) begin
                total++;
                if ({bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_data, bus_if.err_timeout} !== {1'b1, 2'd0, 6'h00, 1'b1}) begin
                    bad++; $display("FAIL timeout_resp got rv=%b id=%0d data=%h err=%b exp 1 0 00 1",
                        bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_data, bus_if.err_timeout);
                end
            end
        end
        tick();
        bus_if.req = 4'b0001;
        tick();
        total++;
        if ({bus_if.flt_push, bus_if.flt_sel} !== {1'b1, 2'd0}) begin
            bad++; $display("FAIL timeout_wrap got push=%b sel=%0d exp 1 0", bus_if.flt_push, bus_if.flt_sel);
        end
        bus_if.req = '0;
        tick();
        bus_if.flt_valid = 1'b1; bus_if.flt_result = 6'h21;
        tick();
        bus_if.flt_valid = 1'b0;
        total++;
        if ({bus_if.rsp_valid, bus_if.rsp_data, bus_if.err_timeout} !== {1'b1, 6'h21, 1'b1}) begin
            bad++; $display("FAIL timeout_sticky got rv=%b data=%h err=%b exp 1 21 1",
                bus_if.rsp_valid, bus_if.rsp_data, bus_if.err_timeout);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        bus_if.req_data = '0; bus_if.req_data[11:6] = 6'h0A; bus_if.req = 4'b0010;
        tick();
        bus_if.req = '0;
        tick();
        total++;
        if (bus_if.busy !== 1'b1) begin
            bad++; $display("FAIL midrst_busy got=%b exp 1", bus_if.busy);
        end
        #2 rst_n = 1'b1;
        #1;
        total++;
        if ({bus_if.gnt, bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_data, bus_if.flt_push,
             bus_if.flt_sel, bus_if.flt_data, bus_if.busy, bus_if.err_timeout} !== 25'd0) begin
            bad++; $display("FAIL midrst_async got gnt=%b rv=%b busy=%b err=%b exp all 0",
                bus_if.gnt, bus_if.rsp_valid, bus_if.busy, bus_if.err_timeout);
        end
        tick();
        total++;
        if (bus_if.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL midrst_norsp got rv=%b exp 0", bus_if.rsp_valid);
        end
        rst_n = 1'b0;
        bus_if.req_data = '0; bus_if.req_data[23:18] = 6'h11; bus_if.req = 4'b1000;
        tick();
        total++;
        if ({bus_if.flt_sel, bus_if.gnt, bus_if.flt_data} !== {2'd3, 4'b1000, 6'h11}) begin
            bad++; $display("FAIL midrst_regrant got sel=%0d gnt=%b data=%h exp 3 1000 11",
                bus_if.flt_sel, bus_if.gnt, bus_if.flt_data);
        end
        bus_if.req = '0;
        tick();
        bus_if.flt_valid = 1'b1; bus_if.flt_result = 6'h0F;
        tick();
        bus_if.flt_valid = 1'b0;
        total++;
        if ({bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_data} !== {1'b1, 2'd3, 6'h0F}) begin
            bad++; $display("FAIL midrst_resp got rv=%b id=%0d data=%h exp 1 3 0f",
                bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_data);
        end
        tick();
    endtask

    task automatic test_boundary_race();
        bus_if.req_data = '0; bus_if.req_data[17:12] = 6'h19; bus_if.req = 4'b0100;
        tick();
        bus_if.req = '0;
        for (int k = 1; k <= T + 1; k++) begin
            tick();
            total++;
            if (bus_if.rsp_valid !== 1'b0) begin
                bad++; $display("FAIL race_early k=%0d got rv=%b exp 0", k, bus_if.rsp_valid);
            end
        end
        bus_if.flt_valid = 1'b1; bus_if.flt_result = 6'h2A;
        tick();
        bus_if.flt_valid = 1'b0;
        total++;
        if ({bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_data, bus_if.err_timeout} !== {1'b1, 2'd2, 6'h2A, 1'b0}) begin
            bad++; $display("FAIL race_resp got rv=%b id=%0d data=%h err=%b exp 1 2 2a 0",
                bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_data, bus_if.err_timeout);
        end
        tick();
    endtask

    task automatic test_withdraw_stray();
        bus_if.req_data = '0; bus_if.req_data[5:0] = 6'h07; bus_if.req_data[11:6] = 6'h08;
        bus_if.req = 4'b0011;
        tick();
        total++;
        if ({bus_if.flt_sel, bus_if.flt_data} !== {2'd0, 6'h07}) begin
            bad++; $display("FAIL wd_issue got sel=%0d data=%h exp 0 07", bus_if.flt_sel, bus_if.flt_data);
        end
        bus_if.req = '0;
        tick();
        bus_if.flt_valid = 1'b1; bus_if.flt_result = 6'h30;
        tick();
        bus_if.flt_valid = 1'b0;
        total++;
        if ({bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_data} !== {1'b1, 2'd0, 6'h30}) begin
            bad++; $display("FAIL wd_resp got rv=%b id=%0d data=%h exp 1 0 30",
                bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_data);
        end
        tick();
        bus_if.flt_valid = 1'b1; bus_if.flt_result = 6'h3F;
        tick(); tick();
        bus_if.flt_valid = 1'b0;
        total++;
        if ({bus_if.busy, bus_if.rsp_valid, bus_if.gnt, bus_if.flt_push, bus_if.rsp_data} !== {7'd0, 6'h30}) begin
            bad++; $display("FAIL stray_valid got busy=%b rv=%b gnt=%b push=%b data=%h exp 0 0 0 0 30",
                bus_if.busy, bus_if.rsp_valid, bus_if.gnt, bus_if.flt_push, bus_if.rsp_data);
        end
        bus_if.req = 4'b0011;
        tick();
        total++;
        if ({bus_if.flt_sel, bus_if.gnt} !== {2'd1, 4'b0010}) begin
            bad++; $display("FAIL stray_rrptr got sel=%0d gnt=%b exp 1 0010", bus_if.flt_sel, bus_if.gnt);
        end
        bus_if.req = '0;
        tick();
        bus_if.flt_valid = 1'b1; bus_if.flt_result = 6'h05;
        tick();
        bus_if.flt_valid = 1'b0;
        total++;
        if ({bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_data} !== {1'b1, 2'd1, 6'h05}) begin
            bad++; $display("FAIL stray_resp got rv=%b id=%0d data=%h exp 1 1 05",
                bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_data);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_reset_mid_wait();
        test_boundary_race();
        test_withdraw_stray();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
